// File: rtl/dallanma_cozucu.sv
// Execute-stage branch resolver: evaluates B/JAL/JALR, feeds the predictor,
// redirects getir on a mispredict and flushes the wrong path.
module dallanma_cozucu #(
  parameter int unsigned TEMIZLE_CEVRIM = 2,
  parameter int unsigned SAYAC_W        = 32
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               ddb_durdur_i,
  input  logic               gecerli_i,
  input  logic [1:0]         tur_i,
  input  logic [2:0]         funct3_i,
  input  logic [30:0]        ps_i,
  input  logic               ctipi_i,
  input  logic [31:0]        rs1_i,
  input  logic [31:0]        rs2_i,
  input  logic [31:0]        imm_i,
  input  logic               ongorulen_atla_i,
  input  logic [30:0]        ongorulen_ps_i,
  output logic [30:0]        atlanan_ps_o,
  output logic               atlanan_ps_gecerli_o,
  output logic [31:0]        donus_adr_o,
  output logic               yonlendir_o,
  output logic [30:0]        yonlendir_ps_o,
  output logic               temizle_o,
  output logic [SAYAC_W-1:0] dallanma_sayisi_o,
  output logic [SAYAC_W-1:0] hata_sayisi_o
);

  localparam int unsigned SAY_W = (TEMIZLE_CEVRIM < 2) ? 1 : $clog2(TEMIZLE_CEVRIM + 1);

  localparam logic [1:0] TUR_B    = 2'd0;
  localparam logic [1:0] TUR_JAL  = 2'd1;
  localparam logic [1:0] TUR_JALR = 2'd2;
  localparam logic [1:0] TUR_YOK  = 2'd3;

  typedef enum logic {BOSTA, TEMIZLE} durum_e;

  durum_e             durum_q;
  logic [SAY_W-1:0]   sayac_q;
  logic               yonlendir_q;
  logic [30:0]        yonlendir_ps_q;
  logic               temizle_q;
  logic [SAYAC_W-1:0] dallanma_q;
  logic [SAYAC_W-1:0] hata_q;

  logic [31:0] pc_c;
  logic [31:0] bdal_hedef_c;
  logic [31:0] jalr_toplam_c;
  logic [31:0] hedef_c;
  logic        atla_c;
  logic        hata_c;
  logic        yakala_c;
  logic [30:0] yonlendir_ps_d;
  logic        unused_hedef0;

  // Outcome, target, link value and mispredict decision
  always_comb begin
    pc_c          = {ps_i, 1'b0};
    bdal_hedef_c  = pc_c + imm_i;
    jalr_toplam_c = rs1_i + imm_i;
    hedef_c       = bdal_hedef_c;
    atla_c        = 1'b0;
    case (tur_i)
      TUR_B: begin
        case (funct3_i)
          3'b000:  atla_c = (rs1_i == rs2_i);
          3'b001:  atla_c = (rs1_i != rs2_i);
          3'b100:  atla_c = ($signed(rs1_i) <  $signed(rs2_i));
          3'b101:  atla_c = ($signed(rs1_i) >= $signed(rs2_i));
          3'b110:  atla_c = (rs1_i <  rs2_i);
          3'b111:  atla_c = (rs1_i >= rs2_i);
          default: atla_c = 1'b0;
        endcase
      end
      TUR_JAL:  atla_c = 1'b1;
      TUR_JALR: begin
        atla_c  = 1'b1;
        hedef_c = {jalr_toplam_c[31:1], 1'b0};
      end
      default:  atla_c = 1'b0;
    endcase
    hata_c = (atla_c != ongorulen_atla_i) |
             (atla_c & ongorulen_atla_i & (hedef_c[31:1] != ongorulen_ps_i));
    yakala_c = gecerli_i & ~ddb_durdur_i & (tur_i != TUR_YOK) & (durum_q == BOSTA);
    yonlendir_ps_d = atla_c ? hedef_c[31:1] : (ps_i + (ctipi_i ? 31'd1 : 31'd2));
  end

  assign unused_hedef0        = hedef_c[0];
  assign atlanan_ps_o         = hedef_c[31:1];
  assign atlanan_ps_gecerli_o = atla_c & gecerli_i;
  assign donus_adr_o          = pc_c + (ctipi_i ? 32'd2 : 32'd4);

  // Resolve/flush FSM with counters and registered redirect outputs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      durum_q        <= BOSTA;
      sayac_q        <= '0;
      yonlendir_q    <= 1'b0;
      yonlendir_ps_q <= '0;
      temizle_q      <= 1'b0;
      dallanma_q     <= '0;
      hata_q         <= '0;
    end else begin
      yonlendir_q <= 1'b0;
      case (durum_q)
        BOSTA: begin
          if (yakala_c) begin
            dallanma_q <= dallanma_q + SAYAC_W'(1);
            if (hata_c) begin
              hata_q         <= hata_q + SAYAC_W'(1);
              yonlendir_q    <= 1'b1;
              yonlendir_ps_q <= yonlendir_ps_d;
              temizle_q      <= 1'b1;
              sayac_q        <= SAY_W'(TEMIZLE_CEVRIM);
              durum_q        <= TEMIZLE;
            end
          end
        end
        TEMIZLE: begin
          // flush runs even while the pipeline is stalled
          sayac_q <= sayac_q - SAY_W'(1);
          if (sayac_q == SAY_W'(1)) begin
            temizle_q <= 1'b0;
            durum_q   <= BOSTA;
          end
        end
        default: begin
          temizle_q <= 1'b0;
          durum_q   <= BOSTA;
        end
      endcase
    end
  end

  assign yonlendir_o       = yonlendir_q;
  assign yonlendir_ps_o    = yonlendir_ps_q;
  assign temizle_o         = temizle_q;
  assign dallanma_sayisi_o = dallanma_q;
  assign hata_sayisi_o     = hata_q;

endmodule

// File: tb/tb_dallanma_cozucu.sv
// Bench for dallanma_cozucu: vector table plus scoreboard of registered results.
module tb_dallanma_cozucu;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        ddb_durdur_i, gecerli_i, ctipi_i, ongorulen_atla_i;
  logic [1:0]  tur_i;
  logic [2:0]  funct3_i;
  logic [30:0] ps_i, ongorulen_ps_i;
  logic [31:0] rs1_i, rs2_i, imm_i;
  logic [30:0] atlanan_ps_o, yonlendir_ps_o;
  logic        atlanan_ps_gecerli_o, yonlendir_o, temizle_o;
  logic [31:0] donus_adr_o, dallanma_sayisi_o, hata_sayisi_o;

  dallanma_cozucu #(.TEMIZLE_CEVRIM(2), .SAYAC_W(32)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .ddb_durdur_i(ddb_durdur_i), .gecerli_i(gecerli_i),
    .tur_i(tur_i), .funct3_i(funct3_i), .ps_i(ps_i), .ctipi_i(ctipi_i),
    .rs1_i(rs1_i), .rs2_i(rs2_i), .imm_i(imm_i),
    .ongorulen_atla_i(ongorulen_atla_i), .ongorulen_ps_i(ongorulen_ps_i),
    .atlanan_ps_o(atlanan_ps_o), .atlanan_ps_gecerli_o(atlanan_ps_gecerli_o),
    .donus_adr_o(donus_adr_o), .yonlendir_o(yonlendir_o), .yonlendir_ps_o(yonlendir_ps_o),
    .temizle_o(temizle_o), .dallanma_sayisi_o(dallanma_sayisi_o), .hata_sayisi_o(hata_sayisi_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic gec; logic dur; logic [1:0] tur; logic [2:0] f3; logic [30:0] ps; logic ct;
    logic [31:0] rs1; logic [31:0] rs2; logic [31:0] imm; logic pa; logic [30:0] pps;
    logic e_tk; logic [30:0] e_tps; logic [31:0] e_don; logic e_mis; logic [30:0] e_rps;
  } vec_t;

  typedef struct {
    logic yon; logic [30:0] yps; logic tem; logic [31:0] dal; logic [31:0] hata;
  } beklenen_t;

  int n_vec = 0;
  int n_mis = 0;
  beklenen_t sb[$];

  // bench-side model of the registered state
  int          m_cnt = 0;
  logic [31:0] m_dal = '0, m_hata = '0;
  logic [30:0] m_yps = '0;

  function automatic vec_t mk(input logic gec, input logic dur, input logic [1:0] tur,
      input logic [2:0] f3, input logic [30:0] ps, input logic ct, input logic [31:0] rs1,
      input logic [31:0] rs2, input logic [31:0] imm, input logic pa, input logic [30:0] pps,
      input logic e_tk, input logic [30:0] e_tps, input logic [31:0] e_don,
      input logic e_mis, input logic [30:0] e_rps);
    vec_t v;
    v.gec = gec; v.dur = dur; v.tur = tur; v.f3 = f3; v.ps = ps; v.ct = ct;
    v.rs1 = rs1; v.rs2 = rs2; v.imm = imm; v.pa = pa; v.pps = pps;
    v.e_tk = e_tk; v.e_tps = e_tps; v.e_don = e_don; v.e_mis = e_mis; v.e_rps = e_rps;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    gecerli_i = v.gec; ddb_durdur_i = v.dur; tur_i = v.tur; funct3_i = v.f3;
    ps_i = v.ps; ctipi_i = v.ct; rs1_i = v.rs1; rs2_i = v.rs2; imm_i = v.imm;
    ongorulen_atla_i = v.pa; ongorulen_ps_i = v.pps;
  endtask

  // drive one vector, check combinational outputs, then the registered result
  task automatic step(input vec_t v, input int idx);
    beklenen_t e, g;
    logic cap;
    @(negedge clk_i);
    drive(v);
    #1;
    if (v.tur != 2'd3) chk($sformatf("v%0d atlanan_ps", idx), 32'(atlanan_ps_o), 32'(v.e_tps));
    chk($sformatf("v%0d atlanan_gecerli", idx), 32'(atlanan_ps_gecerli_o), 32'(v.e_tk));
    chk($sformatf("v%0d donus_adr", idx), donus_adr_o, v.e_don);
    cap = v.gec && !v.dur && (v.tur != 2'd3) && (m_cnt == 0);
    e.yon = 1'b0;
    if (m_cnt > 0) begin
      m_cnt = m_cnt - 1;
    end else if (cap) begin
      m_dal = m_dal + 32'd1;
      if (v.e_mis) begin
        m_hata = m_hata + 32'd1;
        m_yps  = v.e_rps;
        m_cnt  = 2;
        e.yon  = 1'b1;
      end
    end
    e.tem = (m_cnt > 0); e.yps = m_yps; e.dal = m_dal; e.hata = m_hata;
    sb.push_back(e);
    @(posedge clk_i);
    #1;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      g = sb.pop_front();
      chk($sformatf("v%0d yonlendir", idx), 32'(yonlendir_o), 32'(g.yon));
      chk($sformatf("v%0d yonlendir_ps", idx), 32'(yonlendir_ps_o), 32'(g.yps));
      chk($sformatf("v%0d temizle", idx), 32'(temizle_o), 32'(g.tem));
      chk($sformatf("v%0d dallanma_sayisi", idx), dallanma_sayisi_o, g.dal);
      chk($sformatf("v%0d hata_sayisi", idx), hata_sayisi_o, g.hata);
    end
  endtask

  vec_t tbl[25];
  vec_t bos;

  initial begin
    bos = mk(0,0,2'd0,3'b000,31'h0,0,32'h0,32'h0,32'h0,0,31'h0, 0,31'h0,32'h4,0,31'h0);
    tbl[0]  = bos;
    // BEQ correctly predicted taken
    tbl[1]  = mk(1,0,2'd0,3'b000,31'h80,0,32'd5,32'd5,32'h20,1,31'h90, 1,31'h90,32'h104,0,31'h0);
    // BNE equal operands, predicted taken -> fall-through redirect
    tbl[2]  = mk(1,0,2'd0,3'b001,31'h200,0,32'd7,32'd7,32'h40,1,31'h220, 0,31'h220,32'h404,1,31'h202);
    // wrong-path branches arriving during the flush
    tbl[3]  = tbl[2];
    tbl[4]  = tbl[2];
    // JALR, predicted not taken, compressed
    tbl[5]  = mk(1,0,2'd2,3'b000,31'h300,1,32'h1003,32'h0,32'h4,0,31'h0, 1,31'h803,32'h602,1,31'h803);
    tbl[6]  = bos;
    tbl[7]  = bos;
    // BLT -1 < 1 taken, backward target
    tbl[8]  = mk(1,0,2'd0,3'b100,31'h400,0,32'hFFFFFFFF,32'd1,32'hFFFFFFF0,1,31'h3F8, 1,31'h3F8,32'h804,0,31'h0);
    // BLTU same operands not taken
    tbl[9]  = mk(1,0,2'd0,3'b110,31'h400,0,32'hFFFFFFFF,32'd1,32'hFFFFFFF0,0,31'h0, 0,31'h3F8,32'h804,0,31'h0);
    // BGE taken but predicted target wrong
    tbl[10] = mk(1,0,2'd0,3'b101,31'h400,0,32'd1,32'hFFFFFFFF,32'hFFFFFFF0,1,31'h100, 1,31'h3F8,32'h804,1,31'h3F8);
    tbl[11] = bos;
    tbl[12] = bos;
    // BGEU 1 >= 0xFFFFFFFF false
    tbl[13] = mk(1,0,2'd0,3'b111,31'h400,0,32'd1,32'hFFFFFFFF,32'hFFFFFFF0,0,31'h0, 0,31'h3F8,32'h804,0,31'h0);
    // funct3 010 never taken
    tbl[14] = mk(1,0,2'd0,3'b010,31'h400,0,32'd3,32'd3,32'hFFFFFFF0,0,31'h0, 0,31'h3F8,32'h804,0,31'h0);
    // funct3 011 never taken, predicted taken -> mispredict
    tbl[15] = mk(1,0,2'd0,3'b011,31'h400,0,32'd1,32'd2,32'hFFFFFFF0,1,31'h3F8, 0,31'h3F8,32'h804,1,31'h402);
    tbl[16] = bos;
    tbl[17] = bos;
    // JAL at top of address space, target and link wrap
    tbl[18] = mk(1,0,2'd1,3'b000,31'h7FFFFFFF,1,32'h0,32'h0,32'h4,1,31'h1, 1,31'h1,32'h0,0,31'h0);
    // reserved type: not a branch
    tbl[19] = mk(1,0,2'd3,3'b000,31'h80,0,32'd5,32'd5,32'h20,1,31'h90, 0,31'h0,32'h104,0,31'h0);
    // stalled mispredict is not captured
    tbl[20] = mk(1,1,2'd0,3'b001,31'h200,0,32'd7,32'd7,32'h40,1,31'h220, 0,31'h220,32'h404,1,31'h202);
    // not-taken mispredict with fall-through PC wrap
    tbl[21] = mk(1,0,2'd0,3'b000,31'h7FFFFFFF,0,32'd1,32'd2,32'h10,1,31'h5, 0,31'h7,32'h2,1,31'h1);
    tbl[22] = bos;
    tbl[23] = bos;
    // gecerli_i low: nothing resolved
    tbl[24] = mk(0,0,2'd0,3'b000,31'h80,0,32'd5,32'd5,32'h20,1,31'h90, 0,31'h90,32'h104,0,31'h0);

    rst_ni = 1'b0;
    drive(bos);
    repeat (2) @(posedge clk_i);
    #1;
    chk("reset yonlendir", 32'(yonlendir_o), 32'd0);
    chk("reset yonlendir_ps", 32'(yonlendir_ps_o), 32'd0);
    chk("reset temizle", 32'(temizle_o), 32'd0);
    chk("reset dallanma", dallanma_sayisi_o, 32'd0);
    chk("reset hata", hata_sayisi_o, 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    for (int i = 0; i < 25; i++) step(tbl[i], i);

    // reset asserted in the middle of a flush
    step(tbl[2], 100);
    @(negedge clk_i);
    drive(bos);
    rst_ni = 1'b0;
    #1;
    chk("midflush temizle", 32'(temizle_o), 32'd0);
    chk("midflush yonlendir", 32'(yonlendir_o), 32'd0);
    chk("midflush yonlendir_ps", 32'(yonlendir_ps_o), 32'd0);
    chk("midflush dallanma", dallanma_sayisi_o, 32'd0);
    chk("midflush hata", hata_sayisi_o, 32'd0);
    m_cnt = 0; m_dal = '0; m_hata = '0; m_yps = '0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    step(tbl[1], 101);
    step(bos, 102);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
